// File: rtl/systolic_feeder.sv
// NxN operand sequencer for an output-stationary systolic array: captures A/B, streams skewed k-slices, drains, pulses done.
// Optional job counter port o_jobs is enabled by defining SYSTOLIC_FEEDER_JOBCNT_EN.
module systolic_feeder #(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic             o_busy,
    output logic             o_clr,
    output logic             o_en,
    output logic [W*N-1:0]   o_a,
    output logic [W*N-1:0]   o_b,
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    output logic [15:0]      o_jobs,
`endif
    output logic             o_done
);

    localparam int TW   = $clog2(3 * N);
    localparam int LAST = 3 * N - 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           state, state_next;
    logic [TW-1:0]    t, t_next;
    logic [W*N*N-1:0] a_reg, b_reg;
    logic             busy_d, clr_d, en_d, done_d;
    logic [W*N-1:0]   a_d, b_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            t     <= '0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    always_comb begin
        state_next = state;
        t_next     = t;
        case (state)
            S_IDLE: if (i_start) state_next = S_LOAD;
            S_LOAD: begin
                state_next = S_RUN;
                t_next     = '0;
            end
            S_RUN: begin
                if (t == TW'(LAST)) state_next = S_DONE;
                else                t_next     = t + TW'(1);
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so that the registers present them in that state's cycle.
    // Lane r carries A[r][k] and lane c carries B[k][c] exactly when t == lane + k; every other slot is zero.
    always_comb begin
        busy_d = (state_next != S_IDLE);
        clr_d  = (state_next == S_LOAD);
        en_d   = (state_next == S_RUN);
        done_d = (state_next == S_DONE);
        a_d    = '0;
        b_d    = '0;
        if (state_next == S_RUN) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_next) == r + k) begin
                        a_d[r*W +: W] = a_reg[(r*N+k)*W +: W];
                        b_d[r*W +: W] = b_reg[(k*N+r)*W +: W];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (state == S_IDLE && i_start) begin
            a_reg <= i_A;
            b_reg <= i_B;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy <= 1'b0;
            o_clr  <= 1'b0;
            o_en   <= 1'b0;
            o_done <= 1'b0;
            o_a    <= '0;
            o_b    <= '0;
        end else begin
            o_busy <= busy_d;
            o_clr  <= clr_d;
            o_en   <= en_d;
            o_done <= done_d;
            o_a    <= a_d;
            o_b    <= b_d;
        end
    end

`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)       o_jobs <= '0;
        else if (done_d) o_jobs <= o_jobs + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: N=3/W=8 and N=4/W=16 instances, per-cycle timing and lane checks,
// and an array-level result check (skewed lanes replayed through an output-stationary array model vs plain A*B).
module tb_systolic_feeder;

    logic         clk = 1'b0;
    logic         rst, start3, start4;
    logic [71:0]  a3_in, b3_in;
    logic [255:0] a4_in, b4_in;
    logic         busy3, clr3, en3, done3, busy4, clr4, en4, done4;
    logic [23:0]  oa3, ob3;
    logic [63:0]  oa4, ob4;
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    logic [15:0]  jobs3, jobs4;
`endif

    always #5 clk = ~clk;

    systolic_feeder #(.W(8), .N(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .i_A(a3_in), .i_B(b3_in),
        .o_busy(busy3), .o_clr(clr3), .o_en(en3), .o_a(oa3), .o_b(ob3),
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        .o_jobs(jobs3),
`endif
        .o_done(done3)
    );

    systolic_feeder #(.W(16), .N(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_A(a4_in), .i_B(b4_in),
        .o_busy(busy4), .o_clr(clr4), .o_en(en4), .o_a(oa4), .o_b(ob4),
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        .o_jobs(jobs4),
`endif
        .o_done(done4)
    );

    typedef struct {
        logic [71:0]  a;
        logic [71:0]  b;
        logic [287:0] c;
    } vec_t;

    int          compared   = 0;
    int          mismatched = 0;
    int          cur_n      = 3;
    int          jobs_exp   = 0;
    int          ma [4][4];
    int          mb [4][4];
    longint      hist_a [12][4];
    longint      hist_b [12][4];
    longint      cmod [4][4];
    logic [15:0] oa [4];
    logic [15:0] ob [4];
    logic        obusy, oclr, oen, odone;
    vec_t        vecs [4];

    // Present whichever instance is under test through one set of observation signals.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            oa[i] = '0;
            ob[i] = '0;
        end
        if (cur_n == 3) begin
            for (int i = 0; i < 3; i++) begin
                oa[i] = {8'h00, oa3[i*8 +: 8]};
                ob[i] = {8'h00, ob3[i*8 +: 8]};
            end
            obusy = busy3; oclr = clr3; oen = en3; odone = done3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                oa[i] = oa4[i*16 +: 16];
                ob[i] = ob4[i*16 +: 16];
            end
            obusy = busy4; oclr = clr4; oen = en4; odone = done4;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkAllIdle(input string name);
        checkOutput({name, "_busy"}, obusy, 0);
        checkOutput({name, "_clr"},  oclr,  0);
        checkOutput({name, "_en"},   oen,   0);
        checkOutput({name, "_done"}, odone, 0);
        for (int r = 0; r < cur_n; r++) begin
            checkOutput({name, "_a"}, oa[r], 0);
            checkOutput({name, "_b"}, ob[r], 0);
        end
    endtask

    task automatic loadMats(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (n == 3) begin
                    a3_in[(r*3+c)*8 +: 8] = 8'(ma[r][c]);
                    b3_in[(r*3+c)*8 +: 8] = 8'(mb[r][c]);
                end else begin
                    a4_in[(r*4+c)*16 +: 16] = 16'(ma[r][c]);
                    b4_in[(r*4+c)*16 +: 16] = 16'(mb[r][c]);
                end
            end
    endtask

    task automatic randMats(input int n, input int maxv);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                ma[r][c] = int'($urandom_range(0, maxv));
                mb[r][c] = int'($urandom_range(0, maxv));
            end
    endtask

    function automatic longint golden(input int r, input int c, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(ma[r][k]) * longint'(mb[k][c]);
        return s;
    endfunction

    task automatic applyReset();
        rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
        repeat (2) @(negedge clk);
        cur_n = 3; #1 checkAllIdle("reset3");
        cur_n = 4; #1 checkAllIdle("reset4");
        rst = 1'b0;
        jobs_exp = 0;
    endtask

    // Called at the negedge of the cycle in which start is to be sampled (cycle 0).
    task automatic applyStimulus(input int n, input bit hold, input int disturb_t, input int abort_t);
        int t, k;
        cur_n = n;
        loadMats(n);
        if (n == 3) start3 = 1'b1; else start4 = 1'b1;
        for (int cyc = 1; cyc <= 3*n; cyc++) begin
            @(negedge clk);
            t = cyc - 2;
            if (cyc == 1 && !hold) begin start3 = 1'b0; start4 = 1'b0; end
            if (disturb_t >= 0 && t == disturb_t) begin
                start3 = 1'b1;
                a3_in  = {8'($urandom), 32'($urandom), 32'($urandom)};
            end else if (disturb_t >= 0 && t == disturb_t + 1) begin
                start3 = 1'b0;
            end
            checkOutput("clr",  oclr,  cyc == 1);
            checkOutput("en",   oen,   t >= 0 && t <= 3*n-3);
            checkOutput("done", odone, cyc == 3*n);
            checkOutput("busy", obusy, 1);
            for (int r = 0; r < n; r++) begin
                k = t - r;
                checkOutput("lane_a", oa[r], (t >= 0 && t <= 3*n-3 && k >= 0 && k < n) ? ma[r][k] : 0);
                checkOutput("lane_b", ob[r], (t >= 0 && t <= 3*n-3 && k >= 0 && k < n) ? mb[k][r] : 0);
                if (t >= 0 && t <= 3*n-3) begin
                    hist_a[t][r] = longint'(oa[r]);
                    hist_b[t][r] = longint'(ob[r]);
                end
            end
            if (abort_t >= 0 && t == abort_t) begin
                rst = 1'b1;
                @(negedge clk);
                checkAllIdle("abort");
                rst = 1'b0; start3 = 1'b0; start4 = 1'b0;
                @(negedge clk);
                checkAllIdle("post_abort");
                jobs_exp = 0;
                return;
            end
        end
        if (n == 3) jobs_exp++;
        // PE(r,c) sees row r delayed by c hops and column c delayed by r hops.
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                cmod[r][c] = 0;
                for (int tt = 0; tt <= 5*n-5; tt++)
                    if (tt - c >= 0 && tt - c <= 3*n-3 && tt - r >= 0 && tt - r <= 3*n-3)
                        cmod[r][c] += hist_a[tt-c][r] * hist_b[tt-r][c];
            end
        @(negedge clk);
        checkAllIdle("idle_after");
    endtask

    task automatic checkGolden(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                checkOutput("array_C", cmod[r][c], golden(r, c, n));
    endtask

    initial begin
        rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
        a3_in = '0; b3_in = '0; a4_in = '0; b4_in = '0;

        // Vector table: identity x [1..9], all-2 x all-3, two random pairs.
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        ma[r][c] = (i == 0) ? ((r == c) ? 1 : 0) : 2;
                        mb[r][c] = (i == 0) ? (r*3 + c + 1) : 3;
                    end
            end else begin
                randMats(3, 255);
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    vecs[i].a[(r*3+c)*8 +: 8]   = 8'(ma[r][c]);
                    vecs[i].b[(r*3+c)*8 +: 8]   = 8'(mb[r][c]);
                    vecs[i].c[(r*3+c)*32 +: 32] = (i == 0) ? 32'(r*3 + c + 1)
                                                : (i == 1) ? 32'd18 : 32'(golden(r, c, 3));
                end
        end

        applyReset();
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    ma[r][c] = int'(vecs[i].a[(r*3+c)*8 +: 8]);
                    mb[r][c] = int'(vecs[i].b[(r*3+c)*8 +: 8]);
                end
            applyStimulus(3, 1'b0, -1, -1);
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    checkOutput("vec_C", cmod[r][c], longint'(vecs[i].c[(r*3+c)*32 +: 32]));
        end

        // Start pulse and operand change during RUN must not disturb the job.
        randMats(3, 255);
        applyStimulus(3, 1'b0, 2, -1);
        checkGolden(3);
        @(negedge clk);
        checkAllIdle("no_restart");

        // Start held high: three back-to-back jobs, 3N+1 cycles apart.
        applyReset();
        @(negedge clk);
        randMats(3, 255);
        applyStimulus(3, 1'b1, -1, -1);
        checkGolden(3);
        applyStimulus(3, 1'b1, -1, -1);
        checkGolden(3);
        applyStimulus(3, 1'b0, -1, -1);
        checkGolden(3);
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        checkOutput("jobs", jobs3, jobs_exp);
`endif

        // Reset at RUN t=2, then a fresh job.
        randMats(3, 255);
        applyStimulus(3, 1'b0, -1, 2);
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
        checkOutput("jobs_after_abort", jobs3, jobs_exp);
`endif
        randMats(3, 255);
        applyStimulus(3, 1'b0, -1, -1);
        checkGolden(3);

        // N=4, W=16 random jobs.
        for (int j = 0; j < 2; j++) begin
            randMats(4, 65535);
            applyStimulus(4, 1'b0, -1, -1);
            checkGolden(4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
